// File: rtl/rom_fetch.sv
// Byte-wide ROM read initiator: fetches 1-4 consecutive bytes and returns them
// as a little-endian word, aborting with err if the ROM stops answering.
module rom_fetch #(
    parameter int size_addr = 8,
    parameter int TIMEOUT   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [size_addr-1:0] pc,
    input  logic [1:0]           len,
    output logic                 busy,
    output logic                 valid,
    output logic                 err,
    output logic [31:0]          word,
    output logic                 rom_read,
    output logic [size_addr-1:0] rom_address,
    input  logic                 rom_ready,
    input  logic [7:0]           rom_data
);

    typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

    state_t               state, state_d;
    logic [size_addr-1:0] pc_q, pc_d;
    logic [1:0]           len_q, len_d, idx_q, idx_d, nxt_idx;
    logic [7:0]           cnt_q, cnt_d;
    logic [31:0]          asm_q, asm_d, merged, word_d;
    logic                 valid_d, err_d, rom_read_d;
    logic [size_addr-1:0] rom_address_d;
    logic                 timeout_hit;

    assign nxt_idx     = idx_q + 2'd1;
    assign timeout_hit = (cnt_q + 8'd1) == 8'(TIMEOUT);

    always_comb begin
        merged = asm_q;
        merged[{idx_q, 3'b000} +: 8] = rom_data;
    end

    // State register; registered outputs take their next values from the output process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            asm_q       <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            err         <= 1'b0;
            word        <= '0;
            rom_read    <= 1'b0;
            rom_address <= '0;
        end else begin
            state       <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            busy        <= (state_d != IDLE);
            valid       <= valid_d;
            err         <= err_d;
            word        <= word_d;
            rom_read    <= rom_read_d;
            rom_address <= rom_address_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (start) state_d = READ;
            READ: state_d = WAIT;
            WAIT: begin
                // A ready byte takes priority over a timeout on the same edge.
                if (rom_ready)        state_d = (idx_q == len_q) ? IDLE : READ;
                else if (timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        len_d         = len_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        asm_d         = asm_q;
        word_d        = word;
        valid_d       = 1'b0;
        err_d         = 1'b0;
        rom_read_d    = 1'b0;
        rom_address_d = rom_address;
        unique case (state)
            IDLE: begin
                if (start) begin
                    pc_d          = pc;
                    len_d         = len;
                    idx_d         = '0;
                    asm_d         = '0;
                    rom_read_d    = 1'b1;
                    rom_address_d = pc;
                end
            end
            READ: cnt_d = '0;
            WAIT: begin
                if (rom_ready) begin
                    asm_d = merged;
                    if (idx_q == len_q) begin
                        word_d  = merged;
                        valid_d = 1'b1;
                    end else begin
                        idx_d         = nxt_idx;
                        rom_read_d    = 1'b1;
                        rom_address_d = pc_q + size_addr'(nxt_idx);
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    err_d = timeout_hit;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rom_fetch.sv
// Self-checking bench for rom_fetch: ROM model with optional response delay,
// expected words and latencies computed from the memory image.
module tb_rom_fetch;
    localparam int TMO = 8;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0]  pc = '0;
    logic [1:0]  len = '0;
    logic        busy, valid, err, rom_read;
    logic [31:0] word;
    logic [7:0]  rom_address;
    logic        rom_ready = 1'b0;
    logic [7:0]  rom_data = '0;

    int checks = 0, failures = 0;
    logic [7:0]  mem [256];
    logic        ready_en = 1'b1;
    int          extra_delay = 0, pend_cnt = 0, strobe_viol = 0;
    logic [7:0]  pend_addr = '0;
    logic [7:0]  addr_q [$];
    logic        prev_read = 1'b0;
    logic [31:0] model_word = '0;

    rom_fetch #(.size_addr(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .len(len),
        .busy(busy), .valid(valid), .err(err), .word(word),
        .rom_read(rom_read), .rom_address(rom_address),
        .rom_ready(rom_ready), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    // ROM: answers a sampled strobe after 1+extra_delay edges; data is noise otherwise.
    always @(posedge clk) begin
        rom_ready <= 1'b0;
        rom_data  <= 8'($urandom);
        if (rom_read && ready_en) begin
            if (extra_delay == 0) begin
                rom_ready <= 1'b1;
                rom_data  <= mem[rom_address];
            end else begin
                pend_cnt  <= extra_delay;
                pend_addr <= rom_address;
            end
        end else if (pend_cnt > 0) begin
            if (pend_cnt == 1) begin
                rom_ready <= 1'b1;
                rom_data  <= mem[pend_addr];
            end
            pend_cnt <= pend_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (rom_read) begin
            addr_q.push_back(rom_address);
            if (prev_read) strobe_viol++;
        end
        prev_read = rom_read;
    end

    function automatic logic [31:0] exp_word(logic [7:0] p, logic [1:0] l);
        logic [31:0] w = '0;
        for (int i = 0; i <= int'(l); i++) w = w | (32'(mem[8'(p + i)]) << (8 * i));
        return w;
    endfunction

    function automatic bit addr_ok(logic [7:0] p, int n);
        if (addr_q.size() != n) return 1'b0;
        for (int i = 0; i < n; i++) if (addr_q[i] !== 8'(p + i)) return 1'b0;
        return 1'b1;
    endfunction

    // Issues one fetch from IDLE; edges counts from the accept edge (edge 0).
    task automatic run_fetch(input logic [7:0] p, input logic [1:0] l, input int dly,
                             input int poke_at, output int edges,
                             output logic got_valid, output logic got_err);
        extra_delay = dly;
        addr_q.delete();
        start = 1'b1; pc = p; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0; got_valid = 1'b0; got_err = 1'b0;
        while (!got_valid && !got_err && edges < 100) begin
            start = (edges == poke_at);
            if (start) pc = p + 8'h40;
            @(posedge clk); #1;
            edges++;
            got_valid = valid; got_err = err;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (word !== 32'h0) begin failures++; $display("FAIL reset_word got=%h exp=0", word); end
        checks++; if (rom_read !== 1'b0) begin failures++; $display("FAIL reset_rom_read got=%b exp=0", rom_read); end
        checks++; if (rom_address !== 8'h0) begin failures++; $display("FAIL reset_rom_address got=%h exp=0", rom_address); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_four_bytes();
        int e; logic v, er;
        mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
        run_fetch(8'h10, 2'd3, 0, -1, e, v, er);
        checks++; if (!(v === 1'b1 && e == 8)) begin failures++; $display("FAIL four_latency got_edges=%0d valid=%b exp_edges=8", e, v); end
        checks++; if (word !== 32'h44332211) begin failures++; $display("FAIL four_word got=%h exp=44332211", word); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL four_busy_with_valid got=%b exp=0", busy); end
        checks++; if (!addr_ok(8'h10, 4)) begin failures++; $display("FAIL four_addresses got_count=%0d exp=4 from 10", addr_q.size()); end
        model_word = 32'h44332211;
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL four_valid_one_cycle got=%b exp=0", valid); end
    endtask

    task automatic test_single_byte();
        int e; logic v, er;
        mem[8'h05] = 8'hA5;
        run_fetch(8'h05, 2'd0, 0, -1, e, v, er);
        checks++; if (!(v === 1'b1 && e == 2)) begin failures++; $display("FAIL single_latency got_edges=%0d valid=%b exp_edges=2", e, v); end
        checks++; if (word !== 32'h000000A5) begin failures++; $display("FAIL single_word got=%h exp=000000a5", word); end
        checks++; if (!addr_ok(8'h05, 1)) begin failures++; $display("FAIL single_addresses got_count=%0d exp=1", addr_q.size()); end
        model_word = 32'h000000A5;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int e; logic v, er;
        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02; mem[8'h00] = 8'h03; mem[8'h01] = 8'h04;
        run_fetch(8'hFE, 2'd3, 0, -1, e, v, er);
        checks++; if (word !== 32'h04030201) begin failures++; $display("FAIL wrap_word got=%h exp=04030201", word); end
        checks++; if (!addr_ok(8'hFE, 4)) begin failures++; $display("FAIL wrap_addresses got_count=%0d exp=4 from fe", addr_q.size()); end
        model_word = 32'h04030201;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int e; logic v, er;
        logic [7:0] p; logic [1:0] l; int d;
        logic [31:0] exp;
        for (int n = 0; n < 20; n++) begin
            for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
            p = 8'($urandom); l = 2'($urandom); d = int'($urandom_range(0, 3));
            exp = exp_word(p, l);
            run_fetch(p, l, d, -1, e, v, er);
            checks++; if (!(v === 1'b1 && e == (int'(l) + 1) * (2 + d))) begin failures++; $display("FAIL rand_latency n=%0d got_edges=%0d valid=%b exp_edges=%0d", n, e, v, (int'(l) + 1) * (2 + d)); end
            checks++; if (word !== exp) begin failures++; $display("FAIL rand_word n=%0d got=%h exp=%h", n, word, exp); end
            checks++; if (!addr_ok(p, int'(l) + 1)) begin failures++; $display("FAIL rand_addresses n=%0d got_count=%0d exp=%0d", n, addr_q.size(), int'(l) + 1); end
            model_word = exp;
            @(posedge clk); #1;
            checks++; if (valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rand_pulse_end n=%0d valid=%b err=%b exp=0,0", n, valid, err); end
        end
        extra_delay = 0;
    endtask

    task automatic test_timeout();
        int e; logic v, er;
        ready_en = 1'b0;
        run_fetch(8'h33, 2'd2, 0, -1, e, v, er);
        checks++; if (!(er === 1'b1 && v === 1'b0 && e == 1 + TMO)) begin failures++; $display("FAIL timeout_err got_edges=%0d err=%b valid=%b exp_edges=%0d", e, er, v, 1 + TMO); end
        checks++; if (word !== model_word) begin failures++; $display("FAIL timeout_word_kept got=%h exp=%h", word, model_word); end
        checks++; if (addr_q.size() != 1) begin failures++; $display("FAIL timeout_strobes got=%0d exp=1", addr_q.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL timeout_err_one_cycle got=%b exp=0", err); end
        ready_en = 1'b1;
    endtask

    task automatic test_ignore_start();
        int e; logic v, er;
        logic [7:0] p = 8'($urandom);
        logic [31:0] exp = exp_word(p, 2'd3);
        run_fetch(p, 2'd3, 0, 1, e, v, er);
        checks++; if (!(v === 1'b1 && e == 8)) begin failures++; $display("FAIL ignore_latency got_edges=%0d valid=%b exp_edges=8", e, v); end
        checks++; if (word !== exp) begin failures++; $display("FAIL ignore_word got=%h exp=%h", word, exp); end
        checks++; if (!addr_ok(p, 4)) begin failures++; $display("FAIL ignore_addresses got_count=%0d exp=4", addr_q.size()); end
        model_word = exp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int e; logic v, er;
        logic [7:0] p; logic [1:0] l; logic [31:0] exp;
        start = 1'b1; pc = 8'h80; len = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (rom_read !== 1'b0) begin failures++; $display("FAIL rstmid_rom_read got=%b exp=0", rom_read); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", valid); end
        checks++; if (word !== 32'h0) begin failures++; $display("FAIL rstmid_word got=%h exp=0", word); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_word = '0;
        @(posedge clk); #1;
        p = 8'($urandom); l = 2'($urandom); exp = exp_word(p, l);
        run_fetch(p, l, 0, -1, e, v, er);
        checks++; if (!(v === 1'b1 && word === exp)) begin failures++; $display("FAIL rstmid_refetch got=%h valid=%b exp=%h", word, v, exp); end
        model_word = exp;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int ve [2]; logic [31:0] vw [2]; int nv = 0;
        logic [31:0] exp0, exp1;
        mem[8'h20] = 8'($urandom); mem[8'h21] = 8'($urandom);
        mem[8'h30] = 8'($urandom); mem[8'h31] = 8'($urandom);
        exp0 = exp_word(8'h20, 2'd1); exp1 = exp_word(8'h30, 2'd1);
        start = 1'b1; pc = 8'h20; len = 2'd1;
        @(posedge clk); #1;
        pc = 8'h30;
        for (int ed = 1; ed < 20 && nv < 2; ed++) begin
            @(posedge clk); #1;
            if (valid) begin
                ve[nv] = ed; vw[nv] = word; nv++;
                if (nv == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        checks++; if (nv != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", nv); end
        // Second accept is the edge after the first valid cycle, then 4 edges to valid.
        checks++; if (nv == 2 && !(ve[0] == 4 && ve[1] == 9)) begin failures++; $display("FAIL b2b_edges got=%0d,%0d exp=4,9", ve[0], ve[1]); end
        checks++; if (nv == 2 && !(vw[0] === exp0 && vw[1] === exp1)) begin failures++; $display("FAIL b2b_words got=%h,%h exp=%h,%h", vw[0], vw[1], exp0, exp1); end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        test_reset();
        test_four_bytes();
        test_single_byte();
        test_wrap();
        test_random();
        test_timeout();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        checks++; if (strobe_viol != 0) begin failures++; $display("FAIL strobe_single_cycle got=%0d exp=0", strobe_viol); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
